// File: rtl/mmio_pkg.sv
// Shared types and constants for the two-master MMIO bus arbiter and anything
// that decodes the peripheral window it feeds.
package mmio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Index of a bus master: 0 = CPU load/store port, 1 = boot/debug loader.
   typedef logic master_idx_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        write;
      logic [3:0]  byteMask;
   } bus_req_t;

   localparam logic [31:0] GPIO_BASE = 32'hFFFF_FFF0;
   localparam logic [31:0] GPIO_TOP  = 32'hFFFF_FFF3;

   localparam bus_req_t BUS_REQ_NONE = '0;

   function automatic bus_req_t select_req(input master_idx_t grant,
                                           input bus_req_t    req0,
                                           input bus_req_t    req1);
      return (grant == master_idx_t'(1)) ? req1 : req0;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick. Purely combinational; the caller owns and
// updates the last-grant history.
module rr_arbiter2
   import mmio_pkg::*;
(
   input  logic [1:0]  i_req,
   input  master_idx_t i_last_grant,
   output master_idx_t o_grant,
   output logic        o_valid
);

   always_comb begin
      o_valid = |i_req;
      o_grant = master_idx_t'(0);
      case (i_req)
         2'b01:   o_grant = master_idx_t'(0);
         2'b10:   o_grant = master_idx_t'(1);
         // On a tie the master that was not served last goes next.
         2'b11:   o_grant = ~i_last_grant;
         default: o_grant = master_idx_t'(0);
      endcase
   end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter and sequencer that serialises two masters onto the
// single-port MMIO bus: latch request, one-cycle strobe, fixed read wait, done.
module mmio_bus_arbiter
   import mmio_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m0_write,
   input  logic [3:0]  m0_byteMask,
   output logic [31:0] m0_rdata,
   output logic        m0_done,

   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_write,
   input  logic [3:0]  m1_byteMask,
   output logic [31:0] m1_rdata,
   output logic        m1_done,

   output logic [31:0] memAddress,
   output logic [31:0] memWriteData,
   output logic        memWrite,
   output logic [3:0]  byteMask,
   input  logic [31:0] memReadData
);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("mmio_bus_arbiter: READ_LATENCY must be in 1..4");
   end

   localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic [1:0]  r_count;
   logic [1:0]  w_count_next;
   master_idx_t r_last_grant;
   master_idx_t r_grant;
   bus_req_t    r_req;
   logic [31:0] r_rdata [2];

   bus_req_t    w_m0_req;
   bus_req_t    w_m1_req;
   master_idx_t w_arb_grant;
   logic        w_arb_valid;
   logic        w_accept;
   logic        w_capture;
   logic        w_bus_on;

   assign w_m0_req = '{addr: m0_addr, wdata: m0_wdata, write: m0_write, byteMask: m0_byteMask};
   assign w_m1_req = '{addr: m1_addr, wdata: m1_wdata, write: m1_write, byteMask: m1_byteMask};

   rr_arbiter2 u_rr (
      .i_req        ({m1_req, m0_req}),
      .i_last_grant (r_last_grant),
      .o_grant      (w_arb_grant),
      .o_valid      (w_arb_valid)
   );

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_arb_valid) begin
               w_accept     = 1'b1;
               w_state_next = ACCESS;
            end
         end
         ACCESS: begin
            w_state_next = WAIT;
            w_count_next = WAIT_LOAD;
         end
         WAIT: begin
            if (r_count == 2'd0) begin
               // Writes share the timing of reads but leave rdata untouched.
               w_capture    = ~r_req.write;
               w_state_next = RESP;
            end else begin
               w_count_next = r_count - 2'd1;
            end
         end
         RESP: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_count      <= 2'd0;
         r_last_grant <= master_idx_t'(1);
         r_grant      <= master_idx_t'(0);
         r_req        <= BUS_REQ_NONE;
         for (int i = 0; i < 2; i++) begin
            r_rdata[i] <= 32'h0;
         end
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (w_accept) begin
            r_grant      <= w_arb_grant;
            r_last_grant <= w_arb_grant;
            r_req        <= select_req(w_arb_grant, w_m0_req, w_m1_req);
         end
         for (int i = 0; i < 2; i++) begin
            if (w_capture && (r_grant == master_idx_t'(i))) begin
               r_rdata[i] <= memReadData;
            end
         end
      end
   end

   // The bus is forced to zero outside ACCESS/WAIT so idle cycles never
   // look like a peripheral access.
   assign w_bus_on     = (r_state == ACCESS) || (r_state == WAIT);
   assign memAddress   = w_bus_on ? r_req.addr     : 32'h0;
   assign memWriteData = w_bus_on ? r_req.wdata    : 32'h0;
   assign byteMask     = w_bus_on ? r_req.byteMask : 4'h0;
   assign memWrite     = (r_state == ACCESS) && r_req.write;

   assign m0_done  = (r_state == RESP) && (r_grant == master_idx_t'(0));
   assign m1_done  = (r_state == RESP) && (r_grant == master_idx_t'(1));
   assign m0_rdata = r_rdata[0];
   assign m1_rdata = r_rdata[1];

endmodule
